// File: rtl/ins_loader_pkg.sv
// ============================================================================
//  Module   : ins_loader_pkg
//  Brief    : Shared types and constants for the instruction memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ins_loader_pkg;

    // Instruction store geometry
    localparam int DEPTH          = 32;
    localparam int ADDR_W         = 5;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    // Value presented to fetch while the store is not fully programmed
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ins_mem_loader_byte_packer.sv
// ============================================================================
//  Module   : byte_packer
//  Brief    : Collects four stream bytes MSB first into a 32-bit word and
//             pulses word_valid on the cycle the fourth byte is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import ins_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q,    shift_d;

    // Next-state for the byte counter and the three-byte holding register
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clear) begin
            byte_cnt_d = 2'd0;
            shift_d    = 24'd0;
        end else if (accept) begin
            // Counter wraps naturally to 0 after the fourth byte
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], in_byte};
        end
    end

    // Counter and holding register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // The completed word is formed combinationally so it can be written on
    // the same edge that accepts its last byte.
    assign word_valid = accept && !clear && (byte_cnt_q == LAST_BYTE);
    assign word       = {shift_q, in_byte};

endmodule

`default_nettype wire

// File: rtl/ins_mem_loader.sv
// ============================================================================
//  Module   : ins_mem_loader
//  Brief    : Run-time writable instruction store. Fills DEPTH words from a
//             byte-serial valid/ready stream after start, then serves
//             combinational reads to fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_mem_loader
    import ins_loader_pkg::*;
#(
    parameter int DEPTH  = ins_loader_pkg::DEPTH,
    parameter int ADDR_W = ins_loader_pkg::ADDR_W,
    parameter int WORD_W = ins_loader_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              loading,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  word_addr_q, word_addr_d;
    logic [ADDR_W:0]    word_count_q, word_count_d;

    logic               packer_clear;
    logic               accept;
    logic               word_valid;
    logic [31:0]        packed_word;
    logic               mem_we;

    logic [WORD_W-1:0]  mem_q [DEPTH];

    assign in_ready = (state_q == ST_LOAD);
    assign loading  = (state_q == ST_LOAD);
    assign done     = (state_q == ST_DONE);
    assign accept   = in_valid && in_ready;

    byte_packer u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .accept     (accept),
        .in_byte    (in_byte),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    // Next-state, address/count update and memory write strobe
    always_comb begin
        state_d      = state_q;
        word_addr_d  = word_addr_q;
        word_count_d = word_count_q;
        packer_clear = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    word_addr_d  = '0;
                    word_count_d = '0;
                    packer_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                // start is deliberately ignored while a load is in flight
                if (word_valid) begin
                    mem_we       = 1'b1;
                    word_addr_d  = word_addr_q + ADDR_ONE;
                    word_count_d = word_count_q + COUNT_ONE;
                    if (word_addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, write address and completed-word count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_addr_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_addr_q  <= word_addr_d;
            word_count_q <= word_count_d;
        end
    end

    // Instruction array; contents survive reset and are masked by done
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_addr_q] <= WORD_W'(packed_word);
        end
    end

    // Fetch sees a NOP until the store is completely programmed
    always_comb begin
        rd_data = WORD_W'(NOP);
        if (done) begin
            rd_data = mem_q[rd_addr];
        end
    end

    assign word_count = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
// ============================================================================
//  Module   : tb_ins_mem_loader
//  Brief    : Directed self-checking bench for ins_mem_loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_mem_loader;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  in_byte  = 8'd0;
    logic        in_valid = 1'b0;
    logic [4:0]  rd_addr  = 5'd0;
    logic        in_ready;
    logic [31:0] rd_data;
    logic        loading;
    logic        done;
    logic [5:0]  word_count;

    int n_checks = 0;
    int n_fail   = 0;

    ins_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .loading    (loading),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stream bytes first..last of a load where word i = base + i, MSB first
    task automatic send_bytes(input logic [31:0] base, input int first, input int last, input bit gaps);
        for (int j = first; j <= last; j++) begin
            logic [31:0] w;
            int          g;
            w = base + 32'(j / 4);
            if (gaps) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_byte  = 8'hA5;
                    tick();
                    check_eq("count_hold_idle", 32'(word_count), 32'(j / 4));
                end
            end
            rd_addr = 5'(j % 32);
            #1;
            check_eq("rd_zero_in_load", rd_data, 32'h0);
            check_eq("ready_in_load", 32'(in_ready), 32'd1);
            in_byte  = w[(24 - 8 * (j % 4)) +: 8];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check_eq("word_count", 32'(word_count), 32'((j + 1) / 4));
            if (j == 127) check_eq("done_after_last", 32'(done), 32'd1);
            else          check_eq("done_low_in_load", 32'(done), 32'd0);
        end
    endtask

    task automatic verify_mem(input logic [31:0] base, input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            tick();
            check_eq(tag, rd_data, base + 32'(a));
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_loading", 32'(loading), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        tick();
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            tick();
            check_eq("rst_rd_data", rd_data, 32'h0);
        end

        // Continuous load
        pulse_start();
        check_eq("start_loading", 32'(loading), 32'd1);
        check_eq("start_in_ready", 32'(in_ready), 32'd1);
        check_eq("start_count", 32'(word_count), 32'd0);
        send_bytes(32'h2008_0000, 0, 127, 1'b0);
        check_eq("end_loading", 32'(loading), 32'd0);
        check_eq("end_in_ready", 32'(in_ready), 32'd0);
        check_eq("end_count", 32'(word_count), 32'd32);
        rd_addr = 5'd31;
        #1;
        check_eq("rd_last_word", rd_data, 32'h2008_001F);
        verify_mem(32'h2008_0000, "rd_contiguous");

        // Load with idle cycles between bytes
        pulse_start();
        check_eq("restart_done_low", 32'(done), 32'd0);
        send_bytes(32'h2008_0000, 0, 127, 1'b1);
        verify_mem(32'h2008_0000, "rd_gapped");

        // start during LOAD is ignored
        pulse_start();
        send_bytes(32'h3C01_0000, 0, 9, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("mid_start_loading", 32'(loading), 32'd1);
        check_eq("mid_start_count", 32'(word_count), 32'd2);
        send_bytes(32'h3C01_0000, 10, 127, 1'b0);
        verify_mem(32'h3C01_0000, "rd_mid_start");

        // Asynchronous reset in the middle of a load
        pulse_start();
        send_bytes(32'h8C00_0000, 0, 49, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_count", 32'(word_count), 32'd0);
        check_eq("async_rst_loading", 32'(loading), 32'd0);
        check_eq("async_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        rd_addr = 5'd0;
        tick();
        check_eq("stale_hidden", rd_data, 32'h0);
        pulse_start();
        send_bytes(32'h2008_0000, 0, 127, 1'b0);
        verify_mem(32'h2008_0000, "rd_after_rst");

        // Reload from DONE with a new pattern
        pulse_start();
        check_eq("reload_done_low", 32'(done), 32'd0);
        check_eq("reload_rd_zero", rd_data, 32'h0);
        check_eq("reload_count", 32'(word_count), 32'd0);
        send_bytes(32'hFFFF_FF00, 0, 127, 1'b0);
        verify_mem(32'hFFFF_FF00, "rd_reload");

        // rst takes priority over start
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check_eq("rst_wins_loading", 32'(loading), 32'd0);
        check_eq("rst_wins_done", 32'(done), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_eq("rst_wins_idle", 32'(loading), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
